// File: rtl/dff_debounce_pkg.sv
// Shared types and limits for the debounce / edge-detect stage behind the
// synchronous-reset D flip-flop.
package dff_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_LOW_CHK,
    S_HIGH,
    S_HIGH_CHK
  } state_t;

  localparam int MAX_STABLE = 255;

endpackage

// File: rtl/dff_debounce_edge_if.sv
// Bit stream in, debounced level / edge pulses / rising-edge count out.
interface dff_debounce_edge_if #(
  parameter int CNT_W = 8
);
  logic             din;
  logic             clr_cnt;
  logic             dout;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] edge_cnt;

  modport master (output din, clr_cnt, input dout, rise, fall, edge_cnt);
  modport slave  (input din, clr_cnt, output dout, rise, fall, edge_cnt);
endinterface

// File: rtl/dff_debounce_edge_sat_counter.sv
// Saturating up-counter; a clear on the same edge as an increment yields 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] base;

  // Clear is applied before the increment so a colliding event still counts.
  assign base = clr ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (base != CNT_MAX)) begin
      cnt <= base + 1'b1;
    end else begin
      cnt <= base;
    end
  end

endmodule

// File: rtl/dff_debounce_edge.sv
// Debounces an already-registered bit: a new level must be seen on
// STABLE_CYCLES consecutive samples before dout follows it.
module dff_debounce_edge
  import dff_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  dff_debounce_edge_if.slave  bus
);
  localparam int             SC_W = $clog2(STABLE_CYCLES);
  localparam logic [SC_W-1:0] LAST = SC_W'(STABLE_CYCLES - 1);

  generate
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > MAX_STABLE) begin : g_bad_stable
      $error("dff_debounce_edge: STABLE_CYCLES must be in 2..255");
    end
  endgenerate

  state_t          state_q;
  logic [SC_W-1:0] stab_q;
  logic            dout_q;
  logic            rise_q;
  logic            fall_q;
  logic            rise_d;
  logic            fall_d;

  // Acceptance is decoded ahead of the edge so the counter bumps on the
  // same edge that raises the rise pulse.
  assign rise_d = (state_q == S_LOW_CHK)  &&  bus.din && (stab_q == LAST);
  assign fall_d = (state_q == S_HIGH_CHK) && !bus.din && (stab_q == LAST);

  // NOTE: every register in this block uses <= so all next-state terms read
  // the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOW;
      stab_q  <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      case (state_q)
        S_LOW: begin
          if (bus.din) begin
            state_q <= S_LOW_CHK;
            stab_q  <= SC_W'(1);
          end
        end
        S_LOW_CHK: begin
          if (!bus.din) begin
            state_q <= S_LOW;
            stab_q  <= '0;
          end else if (stab_q == LAST) begin
            state_q <= S_HIGH;
            dout_q  <= 1'b1;
            stab_q  <= '0;
          end else begin
            stab_q  <= stab_q + 1'b1;
          end
        end
        S_HIGH: begin
          if (!bus.din) begin
            state_q <= S_HIGH_CHK;
            stab_q  <= SC_W'(1);
          end
        end
        S_HIGH_CHK: begin
          if (bus.din) begin
            state_q <= S_HIGH;
            stab_q  <= '0;
          end else if (stab_q == LAST) begin
            state_q <= S_LOW;
            dout_q  <= 1'b0;
            stab_q  <= '0;
          end else begin
            stab_q  <= stab_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_LOW;
          stab_q  <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_edge_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clr_cnt),
    .inc   (rise_d),
    .cnt   (bus.edge_cnt)
  );

  assign bus.dout = dout_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

endmodule

// File: tb/tb_dff_debounce_edge.sv
// Directed checks of dff_debounce_edge followed by a random burst run through
// a modelled upstream flop, compared cycle by cycle with a run-length model.
module tb_dff_debounce_edge;
  localparam int STABLE  = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  dff_debounce_edge_if #(.CNT_W(CNT_W)) bus ();

  dff_debounce_edge #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: counts consecutive samples that disagree with the level.
  logic m_dout = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_run  = 0, m_cnt = 0;

  logic use_flop = 1'b0, flop_d = 1'b0, flop_q = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_cnt = 0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (bus.din != m_dout) begin
        m_run++;
        if (m_run == STABLE) begin
          m_dout = bus.din;
          m_rise = bus.din;
          m_fall = !bus.din;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
      if (bus.clr_cnt) m_cnt = 0;
      if (m_rise && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
    if (use_flop) begin
      flop_q  = reset ? 1'b0 : flop_d;
      bus.din = flop_q;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.din = 1'b0; bus.clr_cnt = 1'b0;
    ticks(2);
    reset = 1'b0;
  endtask

  logic      seen;
  int        exp_sat [5] = '{1, 2, 3, 3, 3};
  logic      lvl;
  int        len;

  initial begin
    reset = 1'b1; bus.din = 1'b1; bus.clr_cnt = 1'b0;

    // Reset held with din high, then release.
    tick();
    check("rst_dout", bus.dout, 0);
    check("rst_rise", bus.rise, 0);
    check("rst_cnt", bus.edge_cnt, 0);
    tick();
    check("rst_rise2", bus.rise, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rel_rise", bus.rise, (i == 3));
    end
    check("rel_dout", bus.dout, 1);
    check("rel_cnt", bus.edge_cnt, 1);
    tick();
    check("rel_rise_clr", bus.rise, 0);

    // Clean rise then fall.
    do_reset();
    bus.din = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("clean_rise", bus.rise, (i == 3));
      check("clean_dout_hi", bus.dout, (i >= 3));
    end
    bus.din = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("clean_fall", bus.fall, (i == 3));
      check("clean_dout_lo", bus.dout, (i < 3));
      check("clean_no_rise", bus.rise, 0);
    end
    check("clean_cnt", bus.edge_cnt, 1);

    // Glitches: 3-sample pulse, then alternating pattern.
    do_reset();
    seen = 1'b0;
    bus.din = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); seen |= bus.dout | bus.rise | bus.fall; end
    bus.din = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= bus.dout | bus.rise | bus.fall; end
    check("glitch_short", seen, 0);
    for (int i = 0; i < 20; i++) begin
      bus.din = (i % 2 == 1);
      tick();
      seen |= bus.dout | bus.rise | bus.fall;
    end
    check("glitch_toggle", seen, 0);
    check("glitch_cnt", bus.edge_cnt, 0);
    bus.din = 1'b0; ticks(2);
    bus.din = 1'b1; ticks(3);
    bus.din = 1'b0; ticks(1);
    check("short_run_dout", bus.dout, 0);
    bus.din = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("restart_rise", bus.rise, (i == 3));
    end

    // Saturation of the 2-bit counter.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.din = 1'b1; ticks(3);
      tick();
      check("sat_rise", bus.rise, 1);
      check("sat_cnt", bus.edge_cnt, exp_sat[k]);
      bus.din = 1'b0; ticks(4);
    end

    // Clear colliding with a rise, then clear alone.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      bus.din = 1'b1; ticks(4);
      bus.din = 1'b0; ticks(4);
    end
    check("coll_pre_cnt", bus.edge_cnt, 2);
    bus.din = 1'b1; ticks(3);
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    check("coll_rise", bus.rise, 1);
    check("coll_cnt", bus.edge_cnt, 1);
    tick();
    check("coll_hold", bus.edge_cnt, 1);
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    check("clr_alone", bus.edge_cnt, 0);

    // Reset in the middle of a check.
    do_reset();
    bus.din = 1'b1; ticks(2);
    reset = 1'b1;
    tick();
    check("mid_rst_dout", bus.dout, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_rise", bus.rise, (i == 3));
    end

    // Random bursts through the upstream flop versus the model.
    use_flop = 1'b1;
    lvl = 1'b0;
    len = 0;
    for (int c = 0; c < 300; c++) begin
      if (len == 0) begin
        lvl = ~lvl;
        len = $urandom_range(1, 6);
      end
      len--;
      flop_d      = lvl;
      bus.clr_cnt = ($urandom_range(0, 15) == 0);
      reset       = ($urandom_range(0, 63) == 0);
      tick();
      check("gold_dout", bus.dout, m_dout);
      check("gold_rise", bus.rise, m_rise);
      check("gold_fall", bus.fall, m_fall);
      check("gold_cnt", bus.edge_cnt, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dff_debounce_edge.md
Name: dff_debounce_edge

Overview:
- Consumes the registered single-bit stream produced by the synchronous-reset D flip-flop stage (its q output).
- Filters glitches with a consecutive-sample stability check and drives a clean debounced level.
- Emits one-cycle rise/fall pulses and keeps a saturating count of accepted rising edges.
- Sits directly downstream of the flop in the benchmark example set; it exercises FSM, counter and pulse logic in the simulator.

Parameters:
STABLE_CYCLES, 4, consecutive sampled cycles din must hold a new value before it is accepted; legal range 2..255; elaboration error outside this range
CNT_W, 8, width of the rising-edge counter edge_cnt

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
din  input  1  bit from upstream flop q; already registered, so no extra synchroniser
clr_cnt  input  1  synchronous clear of edge_cnt
dout  output  1  debounced level
rise  output  1  one-cycle pulse when dout goes 0->1
fall  output  1  one-cycle pulse when dout goes 1->0
edge_cnt  output  CNT_W  count of accepted rising edges; saturates at all-ones

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset. Sampled only on posedge clk and takes priority over all other inputs.
- Reset values: state=S_LOW, stab_cnt=0, dout=0, rise=0, fall=0, edge_cnt=0.
- All outputs are registered; there is no combinational path from din to any output.
- Internal stab_cnt width is $clog2(STABLE_CYCLES).
- FSM states: S_LOW, S_LOW_CHK, S_HIGH, S_HIGH_CHK.
- S_LOW, din=1: go to S_LOW_CHK, stab_cnt<=1.
- S_LOW, din=0: stay.
- S_LOW_CHK, din=0: glitch rejected; go to S_LOW, stab_cnt<=0, no pulse.
- S_LOW_CHK, din=1, stab_cnt==STABLE_CYCLES-1: go to S_HIGH, dout<=1, rise<=1, stab_cnt<=0.
- S_LOW_CHK, din=1, otherwise: stab_cnt<=stab_cnt+1.
- S_HIGH / S_HIGH_CHK: mirror of the above with din=0 as the candidate value; acceptance sets dout<=0, fall<=1.
- Latency: if E0 is the first posedge sampling the new value, dout changes and the pulse asserts after posedge E0+STABLE_CYCLES-1 (default: 4th consecutive sample).
- rise/fall: high for exactly one cycle, cleared on the next edge; never both high together.
- edge_cnt increments on the same edge that sets rise. At all-ones it holds (no wrap).
- clr_cnt without a rise event: edge_cnt<=0.
- clr_cnt and rise event on the same edge: edge_cnt<=1 (clear first, then count).
- Reset mid-check discards all progress.
- If din is held 1 through reset release: dout stays 0 until STABLE_CYCLES samples after release, then rise pulses once.
- din toggling every cycle: dout never changes and no pulses.
- A run shorter by one sample (STABLE_CYCLES-1 samples) is rejected and stab_cnt restarts from 0.

Decomposition:
- Package dff_debounce_pkg: state_t enum {S_LOW, S_LOW_CHK, S_HIGH, S_HIGH_CHK}; localparam MAX_STABLE=255.
- One natural sub-module: sat_counter (parameter W; ports clk, reset, clr, inc, cnt) implementing the saturating edge_cnt with clear-then-increment priority.
- FSM and stab_cnt stay in the top module.

Test Plan:
- Reset: assert reset 2 cycles with din=1, release -> dout=0, edge_cnt=0, rise=0 during reset; rise pulses exactly 4 edges after release, edge_cnt=1.
- Clean rise, then fall: din 0->1 held 10 cycles, then 0 held 10 -> rise at the 4th sample (one cycle wide), dout=1; fall at the 4th low sample, dout=0; edge_cnt=1.
- Glitch: din high for 3 cycles then low; also din alternating 1/0 for 20 cycles -> dout stays 0, no rise/fall, edge_cnt=0.
- Saturation: CNT_W=2, five accepted rising edges -> edge_cnt sequence 1,2,3,3,3.
- Clear collision: clr_cnt asserted on the same edge as a rise with edge_cnt=2 -> edge_cnt=1. clr_cnt alone -> edge_cnt=0.
- Mid-check reset: din high 2 cycles, reset 1 cycle, din kept high -> no rise until 4 samples after release; stand-alone run with upstream flop driven by a 20-time-unit clock pattern matches a golden model.
